fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Round-robin arbiter that shares the single push port of the 8-bit, 16-deep register-file FIFO among NUM_REQ producers. Each producer offers bytes with a valid/ready handshake and marks the final byte of a burst with last. The arbiter grants one producer at a time, holds the grant for the whole burst, and never pushes while the FIFO reports full. It sits directly in front of the FIFO and drives its push/push_data inputs.

## Interface
- NUM_REQ, 4: number of producers (2..8)
- MAX_BURST, 8: maximum beats per grant; the grant is forced off after this many accepted beats
- IDLE_TIMEOUT, 15: consecutive cycles the granted producer may hold req_valid low before its grant is revoked
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-producer byte valid
- req_last  in  NUM_REQ  per-producer last-beat marker, qualified by req_valid
- req_data  in  8*NUM_REQ  per-producer byte; producer i drives bits [8i+7:8i]
- req_ready  out  NUM_REQ  per-producer accept; a beat transfers when req_valid[i] & req_ready[i]
- fifo_full  in  1  FIFO full flag
- push  out  1  FIFO push strobe
- push_data  out  8  FIFO write data
- grant  out  NUM_REQ  one-hot current owner, all zero when idle
- busy  out  1  high while any grant is held

## Operation
- States: IDLE, BURST.
- IDLE: if any req_valid is high, select the first requester found searching upward from (last_owner+1) mod NUM_REQ, with wrap-around. Register it in grant, clear beat_cnt and idle_cnt, and go to BURST. If no request, stay in IDLE. No beats are accepted in IDLE.
- BURST: owner g = the index set in grant.
  - req_ready = grant & {NUM_REQ{~fifo_full}}.
  - push = req_valid[g] & ~fifo_full.
  - push_data = req_data of g, muxed on grant, and driven in every cycle.
- Accepted beat (push=1):
  - beat_cnt increments.
  - idle_cnt clears.
  - The burst ends if req_last[g]=1 or beat_cnt+1 == MAX_BURST.
- Owner valid low in BURST: idle_cnt increments. The burst ends when idle_cnt+1 == IDLE_TIMEOUT.
- Owner valid high with fifo_full=1: this is a stall. Neither counter advances, and the timeout does not run.
- Burst end: on the next edge, clear grant, set last_owner=g, and return to IDLE.
- Counter widths: beat_cnt is $clog2(MAX_BURST+1) bits and idle_cnt is $clog2(IDLE_TIMEOUT+1) bits. Neither counter may wrap.
- Non-owners always see req_ready=0. Their req_valid and req_data are ignored.
- Reset (any time, including mid-burst):
  - State goes to IDLE.
  - grant=0, busy=0, push=0 (combinationally, since push depends on grant), push_data=0.
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
  - Counters go to 0.

## Timing
- Arbitration latency is 1 cycle. A req_valid first high in cycle t gives grant in cycle t+1, and the first push can occur in cycle t+1.
- Throughput within a burst is 1 beat/cycle while fifo_full=0.
- There is exactly one IDLE bubble cycle between consecutive bursts, including back-to-back bursts from different owners.
- push, req_ready and push_data are combinational from the registered grant, fifo_full and the owner's req_valid/req_data. No other path is combinational.
- fifo_full is sampled in the same cycle as push.
  - A beat presented while full stays pending and the producer must hold it.
  - When full deasserts, the beat is pushed in that same cycle.
- The FIFO's own push & ~full gating is redundant but harmless.
- Simultaneous last and MAX_BURST on one beat cause a single burst end.

## Structure
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_BURST=1'b1;
  - default parameter constants;
  - the byte width constant DATA_W=8, shared with the FIFO.
- Sub-module fifo_arb_rr_pick: a purely combinational picker.
  - Inputs: req_valid and last_owner. Outputs: a one-hot next grant and a found flag.
  - It is instantiated once, and is unit-testable alone.
- The top-level file holds the state register, the counters, the grant register and the output muxing.

## Test plan
- Reset then single producer: req_valid[0]=1 for 3 beats 0x11,0x22,0x33 with last on 0x33. Expect grant=4'b0001 one cycle after valid, push on 3 consecutive cycles with the FIFO holding 0x11,0x22,0x33, then grant=0 and busy=0.
- Round-robin fairness: all four producers request continuously with 1-beat bursts (last=1). Expect owner order 0,1,2,3,0, one beat each, separated by one idle cycle.
- Burst cap: producer 2 sends 12 beats 0x00..0x0B with no last. Expect exactly 8 beats (0x00..0x07) under the first grant, then a re-grant to 2 if it is the sole requester, delivering 0x08..0x0B.
- Full stall: fifo_full forced high for 5 cycles mid-burst with producer 1 holding 0xA5. Expect push=0 and req_ready=0 throughout and no timeout. 0xA5 is pushed in the cycle full drops, exactly once.
- Timeout: producer 3 is granted, then drops valid. Expect grant released after 15 idle cycles, busy=0 on cycle 16, and producer 0 served next if requesting.
- Reset mid-burst: assert rst_n=0 during beat 2 of a 5-beat burst. Expect immediate grant=0 and push=0. After release, requester 0 has priority over a simultaneously requesting requester 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and state encoding for the FIFO push arbiter.
package fifo_arb_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_MAX_BURST    = 8;
    localparam int unsigned DEF_IDLE_TIMEOUT = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester above last_owner, wrapping.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_owner,
    output logic [NUM_REQ-1:0]         next_grant,
    output logic                       found
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        idx        = '0;
        // Offset 1 first so the previous owner is considered last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(last_owner) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                next_grant[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO push port among NUM_REQ producers.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      push,
    output logic [DATA_W-1:0]         push_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  last_owner_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_found;
    logic [IDX_W-1:0]   owner_idx;
    logic               owner_valid;
    logic               owner_last;
    logic               beat_last;
    logic               idle_last;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid  (req_valid),
        .last_owner (last_owner_q),
        .next_grant (pick_grant),
        .found      (pick_found)
    );

    // AND-OR mux keeps push_data at zero whenever no grant is held.
    always_comb begin
        owner_idx = '0;
        push_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner_idx = IDX_W'(i);
            end
            push_data = push_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
        end
    end

    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);
    assign push        = owner_valid & ~fifo_full;
    assign req_ready   = grant & {NUM_REQ{~fifo_full}};
    assign beat_last   = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    assign idle_last   = (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant        <= '0;
            busy         <= 1'b0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q    <= ST_BURST;
                        grant      <= pick_grant;
                        busy       <= 1'b1;
                        beat_cnt_q <= '0;
                        idle_cnt_q <= '0;
                    end
                end
                ST_BURST: begin
                    if (push) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        idle_cnt_q <= '0;
                        if (owner_last || beat_last) begin
                            state_q      <= ST_IDLE;
                            grant        <= '0;
                            busy         <= 1'b0;
                            last_owner_q <= owner_idx;
                        end
                    end else if (!owner_valid) begin
                        // A full-stall (valid high, push low) deliberately skips this branch.
                        if (idle_last) begin
                            state_q      <= ST_IDLE;
                            grant        <= '0;
                            busy         <= 1'b0;
                            last_owner_q <= owner_idx;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: vector table plus multi-cycle corner sequences.
module tb_fifo_push_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        push;
    logic [7:0]  push_data;
    logic [3:0]  grant;
    logic        busy;

    int checks;
    int errors;

    fifo_push_arbiter #(
        .NUM_REQ      (4),
        .MAX_BURST    (8),
        .IDLE_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .push      (push),
        .push_data (push_data),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic        e_push;
        logic [7:0]  e_data;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic f);
        @(posedge clk);
        #1;
        rst_n     = ~r;
        req_valid = v;
        req_last  = l;
        req_data  = d;
        fifo_full = f;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] ALL = 32'h44332211;

    initial begin
        logic [7:0] beat;
        logic       e_push;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Single producer, three beats; then round-robin over all four with 1-beat bursts.
        vecs.push_back('{1'b1, 4'h0, 4'h0, 32'h0,  1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h1, 4'h0, 32'h11, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h1, 4'h0, 32'h11, 1'b0, 1'b1, 8'h11, 4'h1, 4'h1, 1'b1});
        vecs.push_back('{1'b0, 4'h1, 4'h0, 32'h22, 1'b0, 1'b1, 8'h22, 4'h1, 4'h1, 1'b1});
        vecs.push_back('{1'b0, 4'h1, 4'h1, 32'h33, 1'b0, 1'b1, 8'h33, 4'h1, 4'h1, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,  1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 4'h0, 4'h0, 32'h0,  1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b1, 8'h11, 4'h1, 4'h1, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b1, 8'h22, 4'h2, 4'h2, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b1, 8'h33, 4'h4, 4'h4, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b1, 8'h44, 4'h8, 4'h8, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, ALL,    1'b0, 1'b1, 8'h11, 4'h1, 4'h1, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,  1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
            chk($sformatf("vec%0d push/data/grant/ready/busy", i),
                {14'h0, push, push_data, grant, req_ready, busy},
                {14'h0, vecs[i].e_push, vecs[i].e_data, vecs[i].e_grant, vecs[i].e_ready,
                 vecs[i].e_busy});
        end

        // Burst cap: producer 2 offers 12 beats without last; 8 + bubble + 4.
        drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        beat = 8'h00;
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 4'b0100, 4'h0, {8'h00, beat, 16'h0000}, 1'b0);
            e_push = ((c >= 1) && (c <= 8)) || (c >= 10);
            chk($sformatf("cap c%0d push", c), 32'(push), 32'(e_push));
            chk($sformatf("cap c%0d grant", c), 32'(grant),
                (c == 0 || c == 9) ? 32'h0 : 32'h4);
            if (e_push) begin
                chk($sformatf("cap c%0d data", c), 32'(push_data),
                    (c <= 8) ? 32'(c - 1) : 32'(c - 2));
            end
            if (push) beat = beat + 8'h01;
        end

        // Full stall mid-burst on producer 1.
        drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 4'b0010, 4'h0, 32'h00005A00, 1'b0);
        chk("stall arb grant", 32'(grant), 32'h0);
        drive(1'b0, 4'b0010, 4'h0, 32'h00005A00, 1'b0);
        chk("stall beat1", {23'h0, push, push_data}, {23'h0, 1'b1, 8'h5A});
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0010, 4'h0, 32'h0000A500, 1'b1);
            chk($sformatf("stall c%0d push/ready/grant", c),
                {23'h0, push, req_ready, grant}, {23'h0, 1'b0, 4'h0, 4'h2});
        end
        drive(1'b0, 4'b0010, 4'b0010, 32'h0000A500, 1'b0);
        chk("stall release", {15'h0, push, push_data, req_ready, grant},
            {15'h0, 1'b1, 8'hA5, 4'h2, 4'h2});
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        chk("stall after", {27'h0, push, grant}, 32'h0);

        // Idle timeout on producer 3; producer 0 waits and is served next.
        drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 4'b1000, 4'h0, 32'h0, 1'b0);
        chk("tmo arb grant", 32'(grant), 32'h0);
        for (int c = 1; c <= 15; c++) begin
            drive(1'b0, (c >= 2) ? 4'b0001 : 4'b0000, 4'b0001, 32'h77, 1'b0);
            chk($sformatf("tmo c%0d push/busy/grant", c), {26'h0, push, busy, grant},
                {26'h0, 1'b0, 1'b1, 4'h8});
        end
        drive(1'b0, 4'b0001, 4'b0001, 32'h77, 1'b0);
        chk("tmo c16 busy/grant", {27'h0, busy, grant}, 32'h0);
        drive(1'b0, 4'b0001, 4'b0001, 32'h77, 1'b0);
        chk("tmo c17 next owner", {19'h0, push, push_data, grant}, {19'h0, 1'b1, 8'h77, 4'h1});
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        chk("tmo c18 grant", 32'(grant), 32'h0);

        // Reset mid-burst, then requester 0 beats requester 1.
        drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 4'b0001, 4'h0, 32'h01, 1'b0);
        chk("rst arb grant", 32'(grant), 32'h0);
        drive(1'b0, 4'b0001, 4'h0, 32'h01, 1'b0);
        chk("rst beat1", {23'h0, push, push_data}, {23'h0, 1'b1, 8'h01});
        drive(1'b1, 4'b0001, 4'h0, 32'h02, 1'b0);
        chk("rst mid-burst outputs", {14'h0, push, push_data, grant, req_ready, busy}, 32'h0);
        drive(1'b0, 4'b0011, 4'h0, 32'h0000BB02, 1'b0);
        chk("rst release grant", 32'(grant), 32'h0);
        drive(1'b0, 4'b0011, 4'b0011, 32'h0000BB02, 1'b0);
        chk("rst priority", {19'h0, push, push_data, grant}, {19'h0, 1'b1, 8'h02, 4'h1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
